pipe_stage_skid: RTL

Generic parametrised inter-stage pipeline register for the in-order core. It is the successor to the fixed-field ID/EX latch and serves as a reusable building block for IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque payload plus a valid-masked control vector, and implements the valid/ready_go/allow_in handshake with hold and flush. An optional 2-entry skid buffer makes `allow_in_o` a pure flop output, which breaks the combinational allow_in chain across stages.

---
 rtl/pipe_stage_skid_pkg.sv | 24 ++
 rtl/pipe_stage_skid_if.sv | 34 +++
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
// Mode constants mirror the PIPE_SKID_* defines the instantiators use.
package pipe_stage_skid_pkg;

    localparam int unsigned PIPE_SKID_OFF = 0;
    localparam int unsigned PIPE_SKID_ON  = 1;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_occ(skid_state_e st);
        logic [1:0] occ;
        case (st)
            StOne:   occ = 2'd1;
            StFull:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle between an upstream stage, this register and downstream.
// master drives the stage inputs (upstream/downstream side), slave is the register itself.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 32 * 4,
    parameter int unsigned CTRL_W = 8
) ();

    logic              in_valid_i;
    logic              in_ready_go_i;
    logic [DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              allow_in_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic              next_allow_in_i;
    logic              hold_i;
    logic              flush_in_i;
    logic              flush_all_i;
    logic [1:0]        occ_o;

    modport master (
        output in_valid_i, in_ready_go_i, in_data_i, in_ctrl_i,
        output next_allow_in_i, hold_i, flush_in_i, flush_all_i,
        input  allow_in_o, out_valid_o, out_data_o, out_ctrl_o, occ_o
    );

    modport slave (
        input  in_valid_i, in_ready_go_i, in_data_i, in_ctrl_i,
        input  next_allow_in_i, hold_i, flush_in_i, flush_all_i,
        output allow_in_o, out_valid_o, out_data_o, out_ctrl_o, occ_o
    );

endinterface

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline register with valid/ready_go/allow_in handshake, hold and flush.
// SKID=1 adds a second entry so allow_in comes straight from state flops.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = 32 * 4,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = PIPE_SKID_OFF
) (
    input logic              clk,
    input logic              rst_n,
    pipe_stage_skid_if.slave bus
);

    logic              in_fire;
    logic              keep;
    logic              out_fire;
    logic              allow_in;
    logic              main_v;
    logic [1:0]        occ;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;

    assign in_fire  = bus.in_valid_i & bus.in_ready_go_i & allow_in;
    assign keep     = in_fire & ~bus.flush_in_i;
    assign out_fire = main_v & bus.next_allow_in_i & ~bus.hold_i;

    generate
        if (SKID == PIPE_SKID_ON) begin : g_skid
            skid_state_e       state_q, state_d;
            logic [DATA_W-1:0] skid_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic              load_main_in;
            logic              load_main_skid;
            logic              load_skid;

            always_comb begin
                state_d        = state_q;
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_q)
                    StEmpty: begin
                        if (keep) begin
                            state_d      = StOne;
                            load_main_in = 1'b1;
                        end
                    end
                    StOne: begin
                        if (keep && out_fire) begin
                            load_main_in = 1'b1;
                        end else if (keep) begin
                            state_d   = StFull;
                            load_skid = 1'b1;
                        end else if (out_fire) begin
                            state_d = StEmpty;
                        end
                    end
                    StFull: begin
                        if (out_fire) begin
                            state_d        = StOne;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
                // Flush-all wins over everything, including a concurrent accept.
                if (bus.flush_all_i) begin
                    state_d        = StEmpty;
                    load_main_in   = 1'b0;
                    load_main_skid = 1'b0;
                    load_skid      = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= StEmpty;
                end else begin
                    state_q <= state_d;
                end
            end

            // Payload flops are deliberately unreset; validity lives in state_q.
            always_ff @(posedge clk) begin
                if (load_main_in) begin
                    main_data_q <= bus.in_data_i;
                    main_ctrl_q <= bus.in_ctrl_i;
                end else if (load_main_skid) begin
                    main_data_q <= skid_data_q;
                    main_ctrl_q <= skid_ctrl_q;
                end
                if (load_skid) begin
                    skid_data_q <= bus.in_data_i;
                    skid_ctrl_q <= bus.in_ctrl_i;
                end
            end

            assign main_v   = (state_q != StEmpty);
            assign allow_in = (state_q != StFull);
            assign occ      = skid_occ(state_q);
        end else begin : g_single
            logic main_v_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    main_v_q <= 1'b0;
                end else if (bus.flush_all_i) begin
                    main_v_q <= 1'b0;
                end else if (allow_in) begin
                    main_v_q <= keep;
                end
            end

            always_ff @(posedge clk) begin
                if (allow_in && keep && !bus.flush_all_i) begin
                    main_data_q <= bus.in_data_i;
                    main_ctrl_q <= bus.in_ctrl_i;
                end
            end

            assign main_v   = main_v_q;
            assign allow_in = ~main_v_q | out_fire;
            assign occ      = {1'b0, main_v_q};
        end
    endgenerate

    assign bus.allow_in_o  = allow_in;
    assign bus.out_valid_o = main_v;
    assign bus.out_data_o  = main_data_q;
    assign bus.out_ctrl_o  = main_ctrl_q & {CTRL_W{main_v}};
    assign bus.occ_o       = occ;

endmodule
